// File: rtl/ipm_sync_fifo_ctrl_v1_0_if.sv
// Request/status bundle of the sync FIFO controller plus its side-band port to the distributed SDPRAM.
// slave = controller side; master = user logic together with the RAM read-data return.
interface ipm_sync_fifo_ctrl_v1_0_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  almost_full;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   water_level;
    logic                  overflow;
    logic                  underflow;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    modport slave (
        input  wr_en, wr_data, rd_en, ram_rd_data,
        output rd_data, rd_valid, full, almost_full, empty, almost_empty,
               water_level, overflow, underflow,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
    );

    modport master (
        output wr_en, wr_data, rd_en, ram_rd_data,
        input  rd_data, rd_valid, full, almost_full, empty, almost_empty,
               water_level, overflow, underflow,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
    );
endinterface

// File: rtl/ipm_sync_fifo_ctrl_v1_0.sv
// Single-clock FIFO controller for an external distributed SDPRAM; read data is 1 cycle after rd_en.
// Backpressure: writes when full / reads when empty are dropped and flagged by overflow/underflow pulses.
module ipm_sync_fifo_ctrl_v1_0 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    ipm_sync_fifo_ctrl_v1_0_if.slave bus
);
    localparam int D  = 1 << ADDR_WIDTH;
    localparam int PW = ADDR_WIDTH + 1;

    if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10 || DATA_WIDTH < 1 || DATA_WIDTH > 256) begin : g_bad_width
        $error("ipm_sync_fifo_ctrl_v1_0: ADDR_WIDTH must be 4..10 and DATA_WIDTH 1..256");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > D) begin : g_bad_levels
        $error("ipm_sync_fifo_ctrl_v1_0: need 0 <= AE_LEVEL < AF_LEVEL <= 2**ADDR_WIDTH");
    end

    logic                  wr_acc, rd_acc;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full_q, full_d, almost_full_q, almost_full_d;
    logic                  empty_q, empty_d, almost_empty_q, almost_empty_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;

    // Occupancy is the wrap-aware pointer difference, so it cannot drift from the pointers.
    always_comb begin
        wr_acc         = bus.wr_en & ~full_q;
        rd_acc         = bus.rd_en & ~empty_q;
        wptr_d         = wptr_q + PW'(wr_acc);
        rptr_d         = rptr_q + PW'(rd_acc);
        count_d        = wptr_d - rptr_d;
        full_d         = (count_d == PW'(D));
        almost_full_d  = (count_d >= PW'(AF_LEVEL));
        empty_d        = (count_d == '0);
        almost_empty_d = (count_d <= PW'(AE_LEVEL));
        rd_data_d      = rd_acc ? bus.ram_rd_data : rd_data_q;
        rd_valid_d     = rd_acc;
        overflow_d     = bus.wr_en & full_q;
        underflow_d    = bus.rd_en & empty_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // RAM captures the write on the same edge that advances wptr.
    assign bus.ram_wr_en    = wr_acc;
    assign bus.ram_wr_addr  = wptr_q[ADDR_WIDTH-1:0];
    assign bus.ram_wr_data  = bus.wr_data;
    assign bus.ram_rd_addr  = rptr_q[ADDR_WIDTH-1:0];

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.water_level  = wptr_q - rptr_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_ipm_sync_fifo_ctrl_v1_0.sv
// Directed bench for the sync FIFO controller with a behavioural distributed RAM (comb read, clocked write).
module tb_ipm_sync_fifo_ctrl_v1_0;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ipm_sync_fifo_ctrl_v1_0_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ipm_sync_fifo_ctrl_v1_0 #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .AF_LEVEL  (14),
        .AE_LEVEL  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk) begin
        if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    end
    assign bus.ram_rd_data = mem[bus.ram_rd_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dat;
    logic          exp_wr, exp_rd;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_data = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        #1;
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_aempty", 32'(bus.almost_empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_afull", 32'(bus.almost_full), 0);
        chk("rst_level", 32'(bus.water_level), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_unf", 32'(bus.underflow), 0);
        #11 rst = 1'b0;
        tick();

        // 1: fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(i);
            #1;
            chk("fill_wr_addr", 32'(bus.ram_wr_addr), 32'(i - 1));
            chk("fill_wr_en", 32'(bus.ram_wr_en), 1);
            tick();
            chk("fill_level", 32'(bus.water_level), 32'(i));
            chk("fill_empty", 32'(bus.empty), 0);
            chk("fill_afull", 32'(bus.almost_full), 32'(i >= 14));
            chk("fill_full", 32'(bus.full), 32'(i == 16));
            chk("fill_aempty", 32'(bus.almost_empty), 32'(i <= 2));
        end
        bus.wr_en = 1'b0;

        // 2: write while full
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h55;
        #1;
        chk("ovf_ram_wr_en", 32'(bus.ram_wr_en), 0);
        tick();
        bus.wr_en = 1'b0;
        chk("ovf_pulse", 32'(bus.overflow), 1);
        chk("ovf_level", 32'(bus.water_level), 16);
        chk("ovf_full", 32'(bus.full), 1);
        tick();
        chk("ovf_clear", 32'(bus.overflow), 0);

        // 3: simultaneous write/read while full
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.wr_data = 8'h66;
        #1;
        chk("fullrw_ram_wr_en", 32'(bus.ram_wr_en), 0);
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk("fullrw_rd_data", 32'(bus.rd_data), 32'h1);
        chk("fullrw_rd_valid", 32'(bus.rd_valid), 1);
        chk("fullrw_ovf", 32'(bus.overflow), 1);
        chk("fullrw_level", 32'(bus.water_level), 15);
        chk("fullrw_full", 32'(bus.full), 0);
        chk("fullrw_afull", 32'(bus.almost_full), 1);
        tick();
        chk("hold_rd_valid", 32'(bus.rd_valid), 0);
        chk("hold_rd_data", 32'(bus.rd_data), 32'h1);

        // drain 0x02..0x10
        for (int i = 2; i <= 16; i++) begin
            bus.rd_en = 1'b1;
            tick();
            chk("drain_rd_data", 32'(bus.rd_data), 32'(i));
            chk("drain_level", 32'(bus.water_level), 32'(16 - i));
        end
        bus.rd_en = 1'b0;
        chk("drain_empty", 32'(bus.empty), 1);

        // 4: read while empty, then write+read while empty
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("unf_pulse", 32'(bus.underflow), 1);
        chk("unf_rd_valid", 32'(bus.rd_valid), 0);
        chk("unf_rd_data", 32'(bus.rd_data), 32'h10);
        tick();
        chk("unf_clear", 32'(bus.underflow), 0);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.wr_data = 8'h21;
        tick();
        bus.rd_en = 1'b0;
        chk("emptyrw_level", 32'(bus.water_level), 1);
        chk("emptyrw_rd_valid", 32'(bus.rd_valid), 0);
        chk("emptyrw_unf", 32'(bus.underflow), 1);
        chk("emptyrw_empty", 32'(bus.empty), 0);
        q.push_back(8'h21);

        // 5: raise to 5 entries, then random interleaving across the pointer wrap
        for (int i = 2; i <= 5; i++) begin
            bus.wr_data = 8'(8'h20 + i);
            q.push_back(bus.wr_data);
            tick();
        end
        bus.wr_en = 1'b0;
        chk("rand_start_level", 32'(bus.water_level), 5);
        for (int n = 0; n < 40; n++) begin
            bus.wr_en = 1'($urandom_range(0, 1));
            bus.rd_en = 1'($urandom_range(0, 1));
            bus.wr_data = 8'($urandom_range(0, 255));
            exp_wr = bus.wr_en && (q.size() < 16);
            exp_rd = bus.rd_en && (q.size() > 0);
            exp_dat = '0;
            if (exp_rd) exp_dat = q.pop_front();
            if (exp_wr) q.push_back(bus.wr_data);
            tick();
            chk("rand_level", 32'(bus.water_level), 32'(q.size()));
            chk("rand_rd_valid", 32'(bus.rd_valid), 32'(exp_rd));
            if (exp_rd) chk("rand_rd_data", 32'(bus.rd_data), 32'(exp_dat));
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;

        // 6: clear, write 7, then asynchronous reset mid-cycle
        rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        chk("clr_level", 32'(bus.water_level), 0);
        bus.wr_en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            bus.wr_data = 8'(8'h30 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        chk("pre_rst_level", 32'(bus.water_level), 7);
        #2 rst = 1'b1;
        #1;
        chk("arst_empty", 32'(bus.empty), 1);
        chk("arst_level", 32'(bus.water_level), 0);
        chk("arst_full", 32'(bus.full), 0);
        #1 rst = 1'b0;
        tick();
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h0A;
        #1;
        chk("post_rst_wr_addr", 32'(bus.ram_wr_addr), 0);
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("post_rst_rd_data", 32'(bus.rd_data), 32'h0A);
        chk("post_rst_rd_valid", 32'(bus.rd_valid), 1);
        chk("post_rst_empty", 32'(bus.empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
